// File: rtl/fft_pkg.sv
// Shared defaults and types for the FFT twiddle store.
package fft_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_RE,
      S_GET_IM,
      S_WRITE,
      S_DONE
   } loader_state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] re;
      logic [DEF_DATA_W-1:0] im;
   } twiddle_t;

endpackage

// File: rtl/twiddle_ram.sv
// Twiddle coefficient RAM: one synchronous write port, one registered read port,
// synchronous clear of every entry on Reset.
module twiddle_ram
   import fft_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned WIDTH  = 2 * DEF_DATA_W,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read samples the pre-write contents, so a same-address read returns old data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (we) begin
            mem[wr_addr] <= wr_data;
         end
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/twiddle_loader.sv
// Twiddle store writer: packs a re/im byte stream into entries of an internal RAM
// and exposes a registered read port for the butterfly datapath.
module twiddle_loader
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              valid,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   loaded,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] dout_re,
   output logic [DATA_W-1:0] dout_im
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   loader_state_t       state, state_next;
   logic [ADDR_W-1:0]   index;
   logic [DATA_W-1:0]   re_q, im_q;
   logic                clear_cnt, cap_re, cap_im, ram_we;
   logic [2*DATA_W-1:0] rd_word;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // abort is checked before any byte capture or write, so it always wins.
   always_comb begin
      state_next = state;
      clear_cnt  = 1'b0;
      cap_re     = 1'b0;
      cap_im     = 1'b0;
      ram_we     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               clear_cnt  = 1'b1;
               state_next = S_GET_RE;
            end
         end
         S_GET_RE: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (valid) begin
               cap_re     = 1'b1;
               state_next = S_GET_IM;
            end
         end
         S_GET_IM: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (valid) begin
               cap_im     = 1'b1;
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_next = S_IDLE;
            end else begin
               ram_we     = 1'b1;
               state_next = (index == LAST_IDX) ? S_DONE : S_GET_RE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Status outputs are registered copies of the next-state decode.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         index  <= '0;
         loaded <= '0;
         re_q   <= '0;
         im_q   <= '0;
         ready  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (clear_cnt) begin
            index  <= '0;
            loaded <= '0;
         end
         if (cap_re) begin
            re_q <= dataIn;
         end
         if (cap_im) begin
            im_q <= dataIn;
         end
         if (ram_we) begin
            index  <= index + 1'b1;
            loaded <= loaded + 1'b1;
         end
         ready <= (state_next == S_GET_RE) || (state_next == S_GET_IM);
         busy  <= (state_next == S_GET_RE) || (state_next == S_GET_IM) ||
                  (state_next == S_WRITE);
         done  <= (state_next == S_DONE);
      end
   end

   twiddle_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (2 * DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .Clock   (Clock),
      .Reset   (Reset),
      .we      (ram_we),
      .wr_addr (index),
      .wr_data ({re_q, im_q}),
      .rd_addr (address),
      .rd_data (rd_word)
   );

   assign dout_re = rd_word[2*DATA_W-1:DATA_W];
   assign dout_im = rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_twiddle_loader.sv
// Directed + randomized bench for twiddle_loader against a byte-stream/table model.
module tb_twiddle_loader;
   import fft_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset, start, abort, valid;
   logic [7:0] dataIn;
   logic       ready, busy, done;
   logic [3:0] loaded;
   logic [2:0] address;
   logic [7:0] dout_re, dout_im;

   int         n_checks = 0;
   int         n_fail   = 0;

   twiddle_t   m [8];
   int         m_loaded;
   logic [7:0] stream [16];

   always #5 Clock = ~Clock;

   twiddle_loader #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .start   (start),
      .abort   (abort),
      .dataIn  (dataIn),
      .valid   (valid),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .loaded  (loaded),
      .address (address),
      .dout_re (dout_re),
      .dout_im (dout_im)
   );

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic verify_all(input string tag);
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         tick();
         check($sformatf("%s_re[%0d]", tag, a), dout_re, m[a].re);
         check($sformatf("%s_im[%0d]", tag, a), dout_im, m[a].im);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) stream[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic fill_spec();
      for (int i = 0; i < 8; i++) begin
         stream[2*i]   = 8'(8'h10 + 8'h20 * i);
         stream[2*i+1] = 8'(8'h20 + 8'h20 * i);
      end
   endtask

   // One load: bytes flow in stream order whenever valid&&ready; abort is raised
   // on the first cycle the transferred-byte count reaches abort_at (-1 = never).
   // A pair completes into the table on the edge after its imaginary byte, unless
   // abort is high in that cycle. dout is checked every cycle against the table.
   task automatic run_load(input string tag, input bit gap, input int abort_at,
                           input int fixed_addr);
      int  k = 0, wr = 0, ndone = 0, done_cyc = -1;
      bit  pend = 0, xfer, do_abort, finished = 0;
      logic [7:0] exp_re, exp_im;
      abort = 0; valid = 0; start = 1;
      tick();
      start = 0;
      m_loaded = 0;
      check({tag, "_loaded_cleared"}, loaded, 0);
      check({tag, "_busy_start"}, busy, 1);
      for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
         do_abort = (abort_at >= 0) && (k == abort_at);
         abort    = do_abort;
         valid    = (k < 16) && (!gap || (cyc % 2 == 1));
         dataIn   = (k < 16) ? stream[k] : 8'h00;
         address  = (fixed_addr >= 0) ? 3'(fixed_addr) : 3'($urandom_range(0, 7));
         start    = (cyc == 7);
         if (pend) check({tag, "_ready_in_write"}, ready, 0);
         xfer   = valid && ready && !do_abort;
         exp_re = m[address].re;
         exp_im = m[address].im;
         tick();
         check({tag, "_dout_re"}, dout_re, exp_re);
         check({tag, "_dout_im"}, dout_im, exp_im);
         if (pend && !do_abort) begin
            m[wr].re = stream[2*wr];
            m[wr].im = stream[2*wr+1];
            wr++;
            m_loaded++;
         end
         pend = xfer && (k % 2 == 1);
         if (xfer) k++;
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (do_abort) finished = 1;
         else if (done_cyc > 0 && cyc >= done_cyc + 2) finished = 1;
      end
      abort = 0; valid = 0; start = 0;
      check({tag, "_done_pulses"}, ndone, (abort_at >= 0) ? 0 : 1);
      if (abort_at < 0 && !gap) check({tag, "_done_cycle"}, done_cyc, 24);
      check({tag, "_loaded"}, loaded, m_loaded);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_ready_end"}, ready, 0);
   endtask

   initial begin
      Reset = 1; start = 0; abort = 0; valid = 0; dataIn = '0; address = '0;
      for (int i = 0; i < 8; i++) m[i] = '0;
      repeat (3) tick();
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_loaded", loaded, 0);
      check("rst_dout", {dout_re, dout_im}, 0);
      Reset = 0;
      tick();

      // Abort after entry 2's real byte on a freshly cleared table.
      fill_random();
      stream[4] = 8'hAA;
      run_load("abort_re", 0, 5, -1);
      check("abort_loaded2", loaded, 2);
      verify_all("abort_re");

      // Full load of the reference stream, valid held high.
      fill_spec();
      run_load("full", 0, -1, -1);
      check("full_loaded8", loaded, 8);
      address = 3'd3;
      tick();
      check("full_addr3_re", dout_re, 8'h70);
      check("full_addr3_im", dout_im, 8'h80);
      verify_all("full");

      // Same stream with valid toggling.
      run_load("gapped", 1, -1, -1);
      verify_all("gapped");

      // Read-during-write on entry 5: 0x11/0x22 then 0x33/0x44.
      fill_random();
      stream[10] = 8'h11; stream[11] = 8'h22;
      run_load("rdw_prep", 0, -1, -1);
      fill_random();
      stream[10] = 8'h33; stream[11] = 8'h44;
      run_load("rdw", 0, -1, 5);
      verify_all("rdw");

      // Abort coinciding with the write of entry 1 discards it.
      fill_random();
      run_load("abort_wr", 0, 4, -1);
      check("abort_wr_loaded1", loaded, 1);
      verify_all("abort_wr");

      // Reset mid-load clears everything on the following cycle.
      start = 1; tick(); start = 0;
      valid = 1; dataIn = 8'h5A;
      repeat (5) tick();
      Reset = 1; valid = 0;
      tick();
      Reset = 0;
      check("midrst_busy", busy, 0);
      check("midrst_ready", ready, 0);
      check("midrst_done", done, 0);
      check("midrst_loaded", loaded, 0);
      check("midrst_dout", {dout_re, dout_im}, 0);
      for (int i = 0; i < 8; i++) m[i] = '0;
      verify_all("midrst");

      // Reload with inverted data replaces every entry.
      fill_random();
      run_load("reload_a", 1, -1, -1);
      for (int i = 0; i < 16; i++) stream[i] = ~stream[i];
      run_load("reload_b", 0, -1, -1);
      check("reload_loaded8", loaded, 8);
      verify_all("reload");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
